// File: rtl/arm_pkg.sv
// Shared ARM decode definitions: condition codes, shift kinds, data-processing
// opcodes, decode-stage states and the rotated-immediate helper.
package arm_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_e;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    // S_RUN accepts instructions; S_RS spends one cycle reading Rs on port 1
    typedef enum logic {
        S_RUN = 1'b0,
        S_RS  = 1'b1
    } state_e;

    // imm8 rotated right by twice the 4-bit rotate field
    function automatic logic [31:0] rotate_imm(input logic [7:0] imm8, input logic [3:0] rot);
        logic [31:0] w;
        logic [4:0]  amt;
        w   = {24'b0, imm8};
        amt = {rot, 1'b0};
        // a left shift by 32 yields zero, so amt==0 leaves w untouched
        return (w >> amt) | (w << (6'd32 - {1'b0, amt}));
    endfunction

endpackage

// File: rtl/arm_cond_check.sv
// ARM condition-field evaluator; purely combinational, shared with the branch unit.
module arm_cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[3];
    assign z = flags[2];
    assign c = flags[1];
    assign v = flags[0];

    // map each condition code onto the {N,Z,C,V} flags
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_operand_decode.sv
// ARM data-processing decode stage: reads Rn/Rm (and Rs for register shifts),
// evaluates the condition and presents a registered operand bundle to execute.
module arm_operand_decode
    import arm_pkg::*;
#(
    parameter logic [31:0] PC_OFFSET = 32'd8
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [3:0]  rf_read_reg1,
    output logic [3:0]  rf_read_reg2,
    input  logic [31:0] rf_read_data1,
    input  logic [31:0] rf_read_data2,
    input  logic [3:0]  cpsr_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_opcode,
    output logic        out_set_flags,
    output logic [3:0]  out_rd,
    output logic [31:0] out_op1,
    output logic [31:0] out_op2,
    output logic [1:0]  out_shift_type,
    output logic [7:0]  out_shift_amt,
    output logic        out_cond_pass,
    output logic        out_undef
);

    state_e      state, state_next;

    // decode of the incoming word
    logic [3:0]  rn_idx, rm_idx;
    logic [31:0] pc_adj;
    logic [31:0] rn_val, rm_val;
    logic        undef_d, regshift_d, cond_ok, pass_d;
    logic [31:0] op2_d;
    logic [1:0]  st_d;
    logic [7:0]  amt_d;
    logic        xfer;

    // register-shift instruction parked while Rs is read
    logic [3:0]  rs_opcode_q;
    logic        rs_set_q;
    logic [3:0]  rs_rd_q;
    logic [31:0] rs_op1_q, rs_op2_q;
    logic [1:0]  rs_st_q;
    logic        rs_pass_q;
    logic [3:0]  rs_idx_q;
    logic [7:0]  rs_pc_lo_q;
    logic [7:0]  rs_amt;

    assign rn_idx = in_instr[19:16];
    assign rm_idx = in_instr[3:0];
    assign pc_adj = in_pc + PC_OFFSET;
    assign rn_val = (rn_idx == 4'd15) ? pc_adj : rf_read_data1;
    assign rm_val = (rm_idx == 4'd15) ? pc_adj : rf_read_data2;

    arm_cond_check u_cond (
        .cond  (in_instr[31:28]),
        .flags (cpsr_flags),
        .pass  (cond_ok)
    );

    // classify the word and form operand 2 and its shift
    always_comb begin
        undef_d = (in_instr[27:26] != 2'b00)
               || (!in_instr[25] && in_instr[7] && in_instr[4])
               || ((in_instr[24:21] inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN}) && !in_instr[20]);
        regshift_d = !undef_d && !in_instr[25] && in_instr[4];
        pass_d     = cond_ok && !undef_d;
        if (in_instr[25]) begin
            op2_d = rotate_imm(in_instr[7:0], in_instr[11:8]);
            st_d  = SHIFT_LSL;
            amt_d = '0;
        end else begin
            op2_d = rm_val;
            st_d  = in_instr[6:5];
            amt_d = {3'b0, in_instr[11:7]};
        end
    end

    assign in_ready = (state == S_RUN) && (!out_valid || out_ready) && !flush;
    assign xfer     = in_valid && in_ready;

    // R15 as Rs uses the low byte of the accepted instruction's pc + offset
    assign rs_amt = (rs_idx_q == 4'd15) ? rs_pc_lo_q : rf_read_data1[7:0];

    // register-file read indices: Rn/Rm while running, Rs on port 1 in S_RS
    always_comb begin
        rf_read_reg1 = rn_idx;
        rf_read_reg2 = rm_idx;
        if (state == S_RS) begin
            rf_read_reg1 = rs_idx_q;
            rf_read_reg2 = '0;
        end
    end

    // next-state: register shifts detour through S_RS for one cycle
    always_comb begin
        state_next = state;
        case (state)
            S_RUN: if (xfer && regshift_d) state_next = S_RS;
            S_RS:  state_next = S_RUN;
            default: state_next = S_RUN;
        endcase
    end

    // state register; reset and flush both return to S_RUN
    always_ff @(posedge clock) begin
        if (reset || flush) state <= S_RUN;
        else                state <= state_next;
    end

    // output bundle register and register-shift holding registers
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_opcode     <= '0;
            out_set_flags  <= 1'b0;
            out_rd         <= '0;
            out_op1        <= '0;
            out_op2        <= '0;
            out_shift_type <= '0;
            out_shift_amt  <= '0;
            out_cond_pass  <= 1'b0;
            out_undef      <= 1'b0;
            rs_opcode_q    <= '0;
            rs_set_q       <= 1'b0;
            rs_rd_q        <= '0;
            rs_op1_q       <= '0;
            rs_op2_q       <= '0;
            rs_st_q        <= '0;
            rs_pass_q      <= 1'b0;
            rs_idx_q       <= '0;
            rs_pc_lo_q     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            if (state == S_RS) begin
                // S_RS is only entered with the output slot already free
                out_valid      <= 1'b1;
                out_opcode     <= rs_opcode_q;
                out_set_flags  <= rs_set_q;
                out_rd         <= rs_rd_q;
                out_op1        <= rs_op1_q;
                out_op2        <= rs_op2_q;
                out_shift_type <= rs_st_q;
                out_shift_amt  <= rs_amt;
                out_cond_pass  <= rs_pass_q;
                out_undef      <= 1'b0;
            end else if (xfer && !regshift_d) begin
                out_valid      <= 1'b1;
                out_opcode     <= in_instr[24:21];
                out_set_flags  <= in_instr[20];
                out_rd         <= in_instr[15:12];
                out_op1        <= rn_val;
                out_op2        <= op2_d;
                out_shift_type <= st_d;
                out_shift_amt  <= amt_d;
                out_cond_pass  <= pass_d;
                out_undef      <= undef_d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (xfer && regshift_d) begin
                rs_opcode_q <= in_instr[24:21];
                rs_set_q    <= in_instr[20];
                rs_rd_q     <= in_instr[15:12];
                rs_op1_q    <= rn_val;
                rs_op2_q    <= rm_val;
                rs_st_q     <= in_instr[6:5];
                rs_pass_q   <= pass_d;
                rs_idx_q    <= in_instr[11:8];
                rs_pc_lo_q  <= pc_adj[7:0];
            end
        end
    end

endmodule

// File: tb/tb_arm_operand_decode.sv
// Self-checking bench for arm_operand_decode: vector table through a scoreboard,
// plus hand-written latency, backpressure, flush and reset sequences.
module tb_arm_operand_decode;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_ready, out_valid;
    logic [31:0] in_instr, in_pc, rf_read_data1, rf_read_data2;
    logic [3:0]  rf_read_reg1, rf_read_reg2, cpsr_flags;
    logic [3:0]  out_opcode, out_rd;
    logic        out_set_flags, out_cond_pass, out_undef;
    logic [31:0] out_op1, out_op2;
    logic [1:0]  out_shift_type;
    logic [7:0]  out_shift_amt;

    logic [31:0] regs [16];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  flags;
        logic [3:0]  opcode;
        logic        s;
        logic [3:0]  rd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  st;
        logic [7:0]  amt;
        logic        pass;
        logic        undef;
        logic        chk_data;
    } vec_t;

    vec_t vecs [18];
    vec_t sb [$];
    vec_t cur_exp;

    int pass_cnt = 0;
    int total_cnt = 0;

    arm_operand_decode #(.PC_OFFSET(32'd8)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .rf_read_reg1   (rf_read_reg1),
        .rf_read_reg2   (rf_read_reg2),
        .rf_read_data1  (rf_read_data1),
        .rf_read_data2  (rf_read_data2),
        .cpsr_flags     (cpsr_flags),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_opcode     (out_opcode),
        .out_set_flags  (out_set_flags),
        .out_rd         (out_rd),
        .out_op1        (out_op1),
        .out_op2        (out_op2),
        .out_shift_type (out_shift_type),
        .out_shift_amt  (out_shift_amt),
        .out_cond_pass  (out_cond_pass),
        .out_undef      (out_undef)
    );

    always #5 clock = ~clock;

    assign rf_read_data1 = regs[rf_read_reg1];
    assign rf_read_data2 = regs[rf_read_reg2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc, input logic [3:0] flags,
                                input logic [3:0] opcode, input logic s, input logic [3:0] rd,
                                input logic [31:0] op1, input logic [31:0] op2, input logic [1:0] st,
                                input logic [7:0] amt, input logic pass, input logic undef,
                                input logic chk_data);
        vec_t v;
        v.instr = instr; v.pc = pc; v.flags = flags; v.opcode = opcode; v.s = s; v.rd = rd;
        v.op1 = op1; v.op2 = op2; v.st = st; v.amt = amt; v.pass = pass; v.undef = undef;
        v.chk_data = chk_data;
        return v;
    endfunction

    // scoreboard: pop/compare delivered bundles first, then record new acceptances
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_bundle", 32'd1, 32'd0);
                end else begin
                    vec_t e;
                    e = sb.pop_front();
                    chk("cond_pass", {31'b0, out_cond_pass}, {31'b0, e.pass});
                    chk("undef", {31'b0, out_undef}, {31'b0, e.undef});
                    if (e.chk_data) begin
                        chk("opcode", {28'b0, out_opcode}, {28'b0, e.opcode});
                        chk("set_flags", {31'b0, out_set_flags}, {31'b0, e.s});
                        chk("rd", {28'b0, out_rd}, {28'b0, e.rd});
                        chk("op1", out_op1, e.op1);
                        chk("op2", out_op2, e.op2);
                        chk("shift_type", {30'b0, out_shift_type}, {30'b0, e.st});
                        chk("shift_amt", {24'b0, out_shift_amt}, {24'b0, e.amt});
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic drive(input vec_t v);
        in_valid   = 1'b1;
        in_instr   = v.instr;
        in_pc      = v.pc;
        cpsr_flags = v.flags;
        cur_exp    = v;
    endtask

    task automatic idle(input vec_t v);
        in_valid   = 1'b0;
        in_instr   = 32'hFFFF_FFFF;
        in_pc      = 32'hDEAD_BEE0;
        cpsr_flags = ~v.flags;
    endtask

    // offer one instruction until accepted (bounded), returning just after the accept edge
    task automatic send(input vec_t v);
        logic took;
        took = 1'b0;
        drive(v);
        for (int unsigned i = 0; i < 20; i++) begin
            @(negedge clock);
            took = in_ready;
            @(posedge clock);
            #1;
            if (took) break;
        end
        if (!took) chk("accept_timeout", 32'd0, 32'd1);
        idle(v);
    endtask

    task automatic drain();
        for (int unsigned i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(posedge clock);
            #1;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 16; r++) regs[r] = 32'hA000_0000 + r;
        regs[0]  = 32'h0;
        regs[1]  = 32'h11;
        regs[2]  = 32'h5;
        regs[3]  = 32'h121;
        regs[4]  = 32'h8000_0000;
        regs[15] = 32'hDEAD_BEEF;

        //             instr          pc            flags   op    s     rd    op1           op2           st     amt    pass  undef chk
        vecs[0]  = mk(32'hE28214FF, 32'h200,      4'b0000, 4'h4, 1'b0, 4'h1, 32'h5,        32'hFF000000, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1);
        vecs[1]  = mk(32'hE1A0000F, 32'h100,      4'b0000, 4'hD, 1'b0, 4'h0, 32'h0,        32'h108,      2'd0, 8'h00, 1'b1, 1'b0, 1'b1);
        vecs[2]  = mk(32'h02821001, 32'h200,      4'b0000, 4'h4, 1'b0, 4'h1, 32'h5,        32'h1,        2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        vecs[3]  = mk(32'h02821001, 32'h200,      4'b0100, 4'h4, 1'b0, 4'h1, 32'h5,        32'h1,        2'd0, 8'h00, 1'b1, 1'b0, 1'b1);
        vecs[4]  = mk(32'hE0810312, 32'h200,      4'b0000, 4'h4, 1'b0, 4'h0, 32'h11,       32'h5,        2'd0, 8'h21, 1'b1, 1'b0, 1'b1);
        vecs[5]  = mk(32'hE3B030AB, 32'h200,      4'b0000, 4'hD, 1'b1, 4'h3, 32'h0,        32'hAB,       2'd0, 8'h00, 1'b1, 1'b0, 1'b1);
        vecs[6]  = mk(32'hE2454103, 32'h200,      4'b0000, 4'h2, 1'b0, 4'h4, 32'hA0000005, 32'hC0000000, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1);
        vecs[7]  = mk(32'hE3510FFF, 32'h200,      4'b0000, 4'hA, 1'b1, 4'h0, 32'h11,       32'h3FC,      2'd0, 8'h00, 1'b1, 1'b0, 1'b1);
        vecs[8]  = mk(32'hE1410002, 32'h200,      4'b0000, 4'hA, 1'b0, 4'h0, 32'h0,        32'h0,        2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        vecs[9]  = mk(32'hE4000000, 32'h200,      4'b0000, 4'h0, 1'b0, 4'h0, 32'h0,        32'h0,        2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        vecs[10] = mk(32'hE0000090, 32'h200,      4'b0000, 4'h0, 1'b0, 4'h0, 32'h0,        32'h0,        2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        vecs[11] = mk(32'hE08F2FC4, 32'hFFFFFFFC, 4'b0000, 4'h4, 1'b0, 4'h2, 32'h4,        32'h80000000, 2'd2, 8'h1F, 1'b1, 1'b0, 1'b1);
        vecs[12] = mk(32'hC03350E1, 32'h200,      4'b1001, 4'h1, 1'b1, 4'h5, 32'h121,      32'h11,       2'd3, 8'h01, 1'b1, 1'b0, 1'b1);
        vecs[13] = mk(32'hB1A00001, 32'h200,      4'b1000, 4'hD, 1'b0, 4'h0, 32'h0,        32'h11,       2'd0, 8'h00, 1'b1, 1'b0, 1'b1);
        vecs[14] = mk(32'hF1A00001, 32'h200,      4'b0000, 4'hD, 1'b0, 4'h0, 32'h0,        32'h11,       2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        vecs[15] = mk(32'h81A00001, 32'h200,      4'b0110, 4'hD, 1'b0, 4'h0, 32'h0,        32'h11,       2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        vecs[16] = mk(32'hE0810F72, 32'h1F0,      4'b0000, 4'h4, 1'b0, 4'h0, 32'h11,       32'h5,        2'd3, 8'hF8, 1'b1, 1'b0, 1'b1);
        vecs[17] = mk(32'h90810312, 32'h200,      4'b0010, 4'h4, 1'b0, 4'h0, 32'h11,       32'h5,        2'd0, 8'h21, 1'b0, 1'b0, 1'b1);

        // reset state
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; cpsr_flags = '0;
        cur_exp = vecs[0];
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_op1", out_op1, 32'd0);
        chk("rst_op2", out_op2, 32'd0);
        chk("rst_opcode", {28'b0, out_opcode}, 32'd0);
        chk("rst_shift_amt", {24'b0, out_shift_amt}, 32'd0);
        chk("rst_rf_reg1", {28'b0, rf_read_reg1}, 32'd0);
        chk("rst_rf_reg2", {28'b0, rf_read_reg2}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clock);
        #1;

        // vector table at full throughput
        for (int unsigned i = 0; i < 18; i++) send(vecs[i]);
        drain();

        // register-shift latency and Rs read
        send(vecs[4]);
        @(negedge clock);
        chk("rs_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rs_rf_reg1", {28'b0, rf_read_reg1}, 32'd3);
        chk("rs_out_valid_early", {31'b0, out_valid}, 32'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("rs_out_valid", {31'b0, out_valid}, 32'd1);
        chk("rs_shift_amt", {24'b0, out_shift_amt}, 32'h21);
        drain();

        // backpressure: bundle held three cycles while a second waits
        out_ready = 1'b0;
        send(vecs[0]);
        drive(vecs[1]);
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_op1", out_op1, 32'h5);
            chk("bp_op2", out_op2, 32'hFF000000);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clock);
        chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        idle(vecs[1]);
        @(negedge clock);
        chk("bp_second_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_second_op2", out_op2, 32'h108);
        @(posedge clock);
        #1;
        drain();

        // flush while in S_RS discards the instruction
        send(vecs[16]);
        flush = 1'b1;
        void'(sb.pop_back());
        @(negedge clock);
        chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clock);
        #1;
        flush = 1'b0;
        @(negedge clock);
        chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_in_ready_after", {31'b0, in_ready}, 32'd1);
        for (int unsigned i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            @(negedge clock);
            chk("fl_no_bundle", {31'b0, out_valid}, 32'd0);
        end
        @(posedge clock);
        #1;

        // reset while in S_RS emits nothing
        send(vecs[4]);
        reset = 1'b1;
        void'(sb.pop_back());
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rr_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rr_op1", out_op1, 32'd0);
        chk("rr_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("rr_no_bundle", {31'b0, out_valid}, 32'd0);
        @(posedge clock);
        #1;

        // pipeline still works afterwards
        send(vecs[7]);
        send(vecs[16]);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/arm_operand_decode.md
Name: arm_operand_decode

Overview:
- Decode stage placed between instruction fetch and the ALU/barrel shifter.
- Accepts one ARM data-processing instruction at a time over a valid/ready handshake.
- Drives the two read ports of the register file and evaluates the condition field against the current CPSR flags.
- Emits a registered operand bundle to the execute stage. A register-specified shift takes a second cycle to read Rs through read port 1.

Parameters:
- PC_OFFSET, 8, value added to in_pc when R15 is read as an operand (ARM pipeline offset).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush (branch taken downstream).
- in_valid  input  1  fetch holds a valid instruction.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_instr  input  32  instruction word.
- in_pc  input  32  address of in_instr.
- rf_read_reg1  output  4  register file read index 1.
- rf_read_reg2  output  4  register file read index 2.
- rf_read_data1  input  32  combinational read data for index 1.
- rf_read_data2  input  32  combinational read data for index 2.
- cpsr_flags  input  4  {N,Z,C,V} from the register file.
- out_valid  output  1  operand bundle valid.
- out_ready  input  1  execute stage accepts the bundle.
- out_opcode  output  4  instr[24:21].
- out_set_flags  output  1  instr[20].
- out_rd  output  4  instr[15:12].
- out_op1  output  32  Rn value.
- out_op2  output  32  Rm value, or the rotated immediate.
- out_shift_type  output  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- out_shift_amt  output  8  shift amount.
- out_cond_pass  output  1  condition satisfied.
- out_undef  output  1  instruction is not a supported data-processing encoding.

Behaviour:
- Reset: state=S_RUN and out_valid=0. All out_* data outputs are 0, and rf_read_reg1/2 are 0.
- Acceptance: in_ready = (state==S_RUN) && (!out_valid || out_ready) && !flush. A transfer occurs when in_valid && in_ready.
- Operand reads: rf_read_reg1=instr[19:16] (Rn) and rf_read_reg2=instr[3:0] (Rm) are driven combinationally from in_instr while in S_RUN.
- R15 substitution: if an index is 15, the operand is in_pc+PC_OFFSET (32-bit wrap) instead of the read data.
- Immediate form (instr[25]=1): out_op2 = {24'b0,imm8} rotated right by 2*instr[11:8]. out_shift_type=00 and out_shift_amt=0.
- Immediate-shift form (instr[25]=0, instr[4]=0): out_op2=Rm, out_shift_type=instr[6:5], out_shift_amt={3'b0,instr[11:7]}.
- Register-shift form (instr[25]=0, instr[4]=1, instr[7]=0): two-cycle path.
  - Accept cycle: latch the instruction, Rn, Rm and the condition result; go to S_RS. out_valid stays unchanged.
  - S_RS cycle: rf_read_reg1=instr[11:8] (Rs; R15 gives in_pc latched+PC_OFFSET). Capture out_shift_amt=Rs[7:0], assert out_valid, return to S_RUN.
  - S_RS is entered only when the output slot is free, i.e. when in_ready was high.
- Undefined: out_undef=1 when instr[27:26]!=00, or instr[25]=0 && instr[7]=1 && instr[4]=1, or opcode 10xx with S=0. The bundle still issues with out_cond_pass=0.
- Condition codes, evaluated on cpsr_flags in the accept cycle: EQ, NE, CS, CC, MI, PL, VS, VC, HI (C&!Z), LS, GE (N==V), LT, GT (!Z&N==V), LE, AL=1, NV(1111)=0.
- Output register: loads on a transfer (single-cycle forms) or on S_RS completion. It holds all values while out_valid && !out_ready. out_valid clears on out_ready when no new bundle loads.
- Latency: 1 cycle from accept to out_valid for immediate and immediate-shift forms; 2 cycles for register-shift.
- Throughput: 1 instruction per cycle with out_ready held high; 1 per 2 cycles for register-shift.
- flush: next cycle out_valid=0 and state=S_RUN. Any pending S_RS instruction is discarded, and no transfer happens in the flush cycle.
- Reset or flush mid-S_RS: no bundle is emitted for that instruction.
- Reset has priority over flush.

Decomposition:
- Package arm_pkg: condition codes (COND_EQ..COND_NV), shift type constants, data-processing opcode constants, and the state encoding S_RUN/S_RS.
- One sub-module, arm_cond_check: 4-bit cond plus 4-bit flags gives the pass bit, purely combinational. It is reused later by the branch unit.

Test Plan:
- Reset then ADD R1,R2,#0xFF000000 (0xE28214FF); R2=5 -> next cycle out_valid=1, out_opcode=0100, out_op1=5, out_op2=0xFF000000, out_cond_pass=1.
- MOV R0,R15 (0xE1A0000F) at in_pc=0x100 -> out_op2=0x108, out_shift_amt=0.
- ADDEQ with cpsr_flags Z=0 -> out_cond_pass=0. Same instruction with Z=1 -> out_cond_pass=1.
- ADD R0,R1,R2,LSL R3 with R3=0x0000_0121:
  - in_ready=0 in the cycle after accept, and rf_read_reg1=3 during it.
  - out_valid rises 2 cycles after accept with out_shift_amt=0x21.
- Hold out_ready=0 for 3 cycles with 2 instructions queued -> first bundle stable for all 3 cycles, in_ready=0. Second bundle appears the cycle after out_ready=1.
- flush asserted during S_RS -> out_valid=0 next cycle, no bundle issued, in_ready=1 the following cycle.
- Undefined word 0xE0000090 (multiply) -> out_undef=1, out_cond_pass=0.
